// File: rtl/nco_hms_cnt.sv
// NCO-divided 1 Hz tick driving cascaded BCD seconds/minutes/hours counters.
// Define NCO_HMS_12H_EN for 12-hour mode (12,01..11); default is 24-hour mode (00..23).
module nco_hms_cnt #(
    parameter int NCO_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCO_W-1:0] i_nco_num,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic             i_min_inc,
    input  logic             i_hour_inc,
    output logic             o_tick,
    output logic [23:0]      o_bcd,
    output logic             o_day
);

`ifdef NCO_HMS_12H_EN
    localparam logic [3:0] HOUR_H_RST = 4'd1;
    localparam logic [3:0] HOUR_L_RST = 4'd2;
`else
    localparam logic [3:0] HOUR_H_RST = 4'd0;
    localparam logic [3:0] HOUR_L_RST = 4'd0;
`endif

    logic [NCO_W-1:0] div_cnt;
    logic [NCO_W-1:0] div_nxt;
    logic [NCO_W-1:0] term_cnt;
    logic             wrap;

    logic [3:0] sec_l,  sec_h,  min_l,  min_h,  hour_l,  hour_h;
    logic [3:0] sec_l_nxt, sec_h_nxt, min_l_nxt, min_h_nxt, hour_l_nxt, hour_h_nxt;

    logic min_carry;
    logic min_adv;
    logic min_wrap;
    logic hour_carry;
    logic hour_adv;
    logic hour_roll;
    logic day_nxt;

    // Divider compares against the live terminal count, so lowering it below
    // the running count forces a wrap instead of a run to 2^NCO_W.
    always_comb begin
        term_cnt = (i_nco_num > NCO_W'(1)) ? (i_nco_num - NCO_W'(1)) : '0;
        wrap     = i_run && (div_cnt >= term_cnt);
        if (wrap) begin
            div_nxt = '0;
        end else if (i_run) begin
            div_nxt = div_cnt + NCO_W'(1);
        end else begin
            div_nxt = div_cnt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sec_l_nxt = sec_l;
        sec_h_nxt = sec_h;
        min_carry = 1'b0;
        if (wrap) begin
            if (sec_l >= 4'd9) begin
                sec_l_nxt = 4'd0;
                if (sec_h >= 4'd5) begin
                    sec_h_nxt = 4'd0;
                    min_carry = 1'b1;
                end else begin
                    sec_h_nxt = sec_h + 4'd1;
                end
            end else begin
                sec_l_nxt = sec_l + 4'd1;
            end
        end
    end

    // A set pulse and a carry in the same cycle are OR-ed into a single advance;
    // only a carry-driven minute wrap propagates into the hours.
    always_comb begin
        min_adv    = min_carry | i_min_inc;
        min_l_nxt  = min_l;
        min_h_nxt  = min_h;
        min_wrap   = 1'b0;
        if (min_adv) begin
            if (min_l >= 4'd9) begin
                min_l_nxt = 4'd0;
                if (min_h >= 4'd5) begin
                    min_h_nxt = 4'd0;
                    min_wrap  = 1'b1;
                end else begin
                    min_h_nxt = min_h + 4'd1;
                end
            end else begin
                min_l_nxt = min_l + 4'd1;
            end
        end
        hour_carry = min_wrap & min_carry;
    end

    always_comb begin
        hour_adv   = hour_carry | i_hour_inc;
        hour_h_nxt = hour_h;
        hour_l_nxt = hour_l;
        hour_roll  = 1'b0;
        if (hour_adv) begin
`ifdef NCO_HMS_12H_EN
            if ((hour_h != 4'd0) && (hour_l >= 4'd2)) begin
                hour_h_nxt = 4'd0;
                hour_l_nxt = 4'd1;
            end else if ((hour_h != 4'd0) && (hour_l == 4'd1)) begin
                hour_h_nxt = 4'd1;
                hour_l_nxt = 4'd2;
                hour_roll  = 1'b1;
            end else if (hour_l >= 4'd9) begin
                hour_h_nxt = 4'd1;
                hour_l_nxt = 4'd0;
            end else begin
                hour_l_nxt = hour_l + 4'd1;
            end
`else
            if ((hour_h >= 4'd2) && (hour_l >= 4'd3)) begin
                hour_h_nxt = 4'd0;
                hour_l_nxt = 4'd0;
                hour_roll  = 1'b1;
            end else if (hour_l >= 4'd9) begin
                hour_h_nxt = hour_h + 4'd1;
                hour_l_nxt = 4'd0;
            end else begin
                hour_l_nxt = hour_l + 4'd1;
            end
`endif
        end
        day_nxt = hour_roll & hour_carry;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            div_cnt <= '0;
            sec_l   <= 4'd0;
            sec_h   <= 4'd0;
            min_l   <= 4'd0;
            min_h   <= 4'd0;
            hour_l  <= HOUR_L_RST;
            hour_h  <= HOUR_H_RST;
            o_tick  <= 1'b0;
            o_day   <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            sec_l   <= sec_l_nxt;
            sec_h   <= sec_h_nxt;
            min_l   <= min_l_nxt;
            min_h   <= min_h_nxt;
            hour_l  <= hour_l_nxt;
            hour_h  <= hour_h_nxt;
            o_tick  <= wrap;
            o_day   <= day_nxt;
        end
    end

    assign o_bcd = {hour_h, hour_l, min_h, min_l, sec_h, sec_l};

endmodule

// File: tb/tb_nco_hms_cnt.sv
// Scoreboard bench for nco_hms_cnt: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them. Follows NCO_HMS_12H_EN if defined.
module tb_nco_hms_cnt;

`ifdef NCO_HMS_12H_EN
    localparam int RST_H = 12;
    localparam int PRE_H = 11;
`else
    localparam int RST_H = 0;
    localparam int PRE_H = 23;
`endif
    localparam int N_PRE = (RST_H == 12) ? 11 : 23;

    typedef struct {
        int          cyc;
        logic        tick;
        logic        day;
        logic [23:0] bcd;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_nco_num = 32'd4;
    logic        i_run = 1'b0;
    logic        i_clr = 1'b0;
    logic        i_min_inc = 1'b0;
    logic        i_hour_inc = 1'b0;
    logic        o_tick;
    logic [23:0] o_bcd;
    logic        o_day;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    logic tick_seen;
    logic bcd_ok;
    exp_t e;

    nco_hms_cnt #(.NCO_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_nco_num (i_nco_num),
        .i_run     (i_run),
        .i_clr     (i_clr),
        .i_min_inc (i_min_inc),
        .i_hour_inc(i_hour_inc),
        .o_tick    (o_tick),
        .o_bcd     (o_bcd),
        .o_day     (o_day)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    function automatic logic [23:0] hms(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic expect_at(input int n, input logic t, input logic d,
                             input logic [23:0] b, input string nm);
        exp_t x;
        x.cyc  = cyc + n;
        x.tick = t;
        x.day  = d;
        x.bcd  = b;
        x.name = nm;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare queued expectations on their cycle, flag unexpected ticks, check digit ranges.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            tick_seen = 1'b0;
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check(e.name, {6'd0, o_tick, o_day, o_bcd}, {6'd0, e.tick, e.day, e.bcd});
                if (e.tick) tick_seen = 1'b1;
            end
            if (o_tick === 1'b1 && !tick_seen) check("unexpected_tick", {31'd0, o_tick}, 32'd0);
            bcd_ok = (o_bcd[3:0] <= 4'd9) && (o_bcd[7:4] <= 4'd5) && (o_bcd[11:8] <= 4'd9) &&
                     (o_bcd[15:12] <= 4'd5) && (o_bcd[19:16] <= 4'd9) && (o_bcd[23:20] <= 4'd2);
            check("bcd_valid", {31'd0, bcd_ok}, 32'd1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        step(3);
        // Reset state, then nco=4 ticks at cycles 4, 8, 12.
        expect_at(0, 1'b0, 1'b0, hms(RST_H, 0, 0), "reset_state");
        rst = 1'b0;
        i_run = 1'b1;
        i_nco_num = 32'd4;
        expect_at(4,  1'b1, 1'b0, hms(RST_H, 0, 1), "first_tick");
        expect_at(8,  1'b1, 1'b0, hms(RST_H, 0, 2), "second_tick");
        expect_at(12, 1'b1, 1'b0, hms(RST_H, 0, 3), "third_tick");
        step(12);

        // Pause 10 cycles with divider at 2: tick slips from +4 to +14.
        step(2);
        i_run = 1'b0;
        expect_at(12, 1'b1, 1'b0, hms(RST_H, 0, 4), "pause_tick");
        step(10);
        i_run = 1'b1;
        step(2);

        // Clear on a would-be wrap: tick suppressed, next tick 4 cycles after clear drops.
        step(3);
        i_clr = 1'b1;
        expect_at(1, 1'b0, 1'b0, hms(RST_H, 0, 0), "clr_state");
        expect_at(5, 1'b1, 1'b0, hms(RST_H, 0, 1), "post_clr_tick");
        step(1);
        i_clr = 1'b0;
        step(4);

        // Lower nco from 100 to 3 while the divider sits at 50.
        i_nco_num = 32'd100;
        step(50);
        i_nco_num = 32'd3;
        expect_at(1, 1'b1, 1'b0, hms(RST_H, 0, 2), "lowered_nco_wrap");
        expect_at(4, 1'b1, 1'b0, hms(RST_H, 0, 3), "period3_a");
        expect_at(7, 1'b1, 1'b0, hms(RST_H, 0, 4), "period3_b");
        step(7);

        // Time-set with the divider frozen.
        i_run = 1'b0;
        i_clr = 1'b1;
        expect_at(1, 1'b0, 1'b0, hms(RST_H, 0, 0), "clr_before_set");
        step(1);
        i_clr = 1'b0;
        i_hour_inc = 1'b1;
        expect_at(1,     1'b0, 1'b0, hms(1, 0, 0),     "hour_set_latency");
        expect_at(N_PRE, 1'b0, 1'b0, hms(PRE_H, 0, 0), "hour_set_held");
        step(N_PRE);
        i_hour_inc = 1'b0;
        i_min_inc = 1'b1;
        expect_at(59,  1'b0, 1'b0, hms(PRE_H, 59, 0), "min_set_59");
        expect_at(60,  1'b0, 1'b0, hms(PRE_H, 0, 0),  "min_inc_wrap_no_hour");
        expect_at(119, 1'b0, 1'b0, hms(PRE_H, 59, 0), "min_set_59_again");
        step(119);
        i_min_inc = 1'b0;
        i_hour_inc = 1'b1;
        expect_at(1,         1'b0, 1'b0, hms(RST_H, 59, 0), "hour_inc_wrap_no_day");
        expect_at(N_PRE + 1, 1'b0, 1'b0, hms(PRE_H, 59, 0), "hour_set_again");
        step(N_PRE + 1);
        i_hour_inc = 1'b0;

        // Tick up to the day wrap with nco=1.
        i_nco_num = 32'd1;
        i_run = 1'b1;
        for (int s = 1; s <= 59; s++)
            expect_at(s, 1'b1, 1'b0, hms(PRE_H, 59, s), $sformatf("preload_sec_%0d", s));
        expect_at(60, 1'b1, 1'b1, hms(RST_H, 0, 0), "day_wrap");
        expect_at(61, 1'b1, 1'b0, hms(RST_H, 0, 1), "day_one_cycle");
        step(61);

        // Seconds carry and min_inc together advance the minute once.
        for (int s = 2; s <= 59; s++)
            expect_at(s - 1, 1'b1, 1'b0, hms(RST_H, 0, s), $sformatf("carry_sec_%0d", s));
        expect_at(59, 1'b1, 1'b0, hms(RST_H, 1, 0), "carry_and_min_inc");
        step(58);
        i_min_inc = 1'b1;
        step(1);
        i_min_inc = 1'b0;
        i_run = 1'b0;

        // Reset mid-run, then 60 ticks with nco=1.
        rst = 1'b1;
        expect_at(1, 1'b0, 1'b0, hms(RST_H, 0, 0), "reset_again");
        step(1);
        rst = 1'b0;
        i_run = 1'b1;
        for (int s = 1; s <= 59; s++)
            expect_at(s, 1'b1, 1'b0, hms(RST_H, 0, s), $sformatf("nco1_sec_%0d", s));
        expect_at(60, 1'b1, 1'b0, hms(RST_H, 1, 0), "nco1_minute");
        step(60);

        // nco=0 also wraps every running cycle.
        i_nco_num = 32'd0;
        expect_at(1, 1'b1, 1'b0, hms(RST_H, 1, 1), "nco0_a");
        expect_at(2, 1'b1, 1'b0, hms(RST_H, 1, 2), "nco0_b");
        step(2);
        i_run = 1'b0;
        step(3);

        check("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nco_hms_cnt.md
# nco_hms_cnt

NCO-driven hours/minutes/seconds BCD counter: the upstream stage feeding the 6-digit seven-segment display driver in the NCO/counter/display chain. It divides the 50 MHz system clock into a 1 Hz tick using a programmable terminal count. On each tick it advances cascaded BCD counters (mod-60 seconds, mod-60 minutes, mod-24 hours). It presents six 4-bit BCD digits plus a tick strobe to the display stage.

## Interface
- `NCO_W`, default 32: width of the NCO terminal-count input and internal divider counter.
- `clk`  input  1  system clock, 50 MHz nominal.
- `rst`  input  1  synchronous, active-high reset.
- `i_nco_num`  input  NCO_W  terminal count, in clk cycles per tick; 50_000_000 gives 1 Hz.
- `i_run`  input  1  1 = divider counts; 0 = divider and time are frozen.
- `i_clr`  input  1  synchronous clear of the divider and of all time digits.
- `i_min_inc`  input  1  single-cycle pulse that adds one minute (time-set).
- `i_hour_inc`  input  1  single-cycle pulse that adds one hour (time-set).
- `o_tick`  output  1  one-cycle strobe on each divider wrap.
- `o_bcd`  output  24  {hour_h, hour_l, min_h, min_l, sec_h, sec_l}, 4 bits each, where [3:0] = sec_l.
- `o_day`  output  1  one-cycle strobe on the hour wrap (23→00 in 24 h mode; 11→12 in 12 h mode).

## Operation
- **Divider.**
  - `div_cnt` (NCO_W bits) increments each cycle while `i_run`=1.
  - When `div_cnt >= i_nco_num-1`, `div_cnt` is set to 0 and a wrap occurs.
  - If `i_nco_num` is 0 or 1, a wrap occurs every running cycle.
  - Comparison uses the live `i_nco_num`. If it is lowered below the current count, the divider wraps on the next running cycle; it never runs to 2^NCO_W.
- **Seconds.**
  - A wrap advances `sec`: sec_l 0–9; sec_h 0–5.
  - 59→00 generates a minute carry.
- **Minutes.**
  - The minute carry or `i_min_inc` advances `min` 00–59.
  - Both in the same cycle advance the minute by exactly one; they are OR-ed, not summed.
  - 59→00 generates an hour carry, except when the advance came only from `i_min_inc`. Setting minutes never touches hours.
- **Hours.**
  - The hour carry or `i_hour_inc` advances `hour` 00–23; both in the same cycle advance it by one.
  - `o_day` pulses only on a carry-driven wrap, not on an `i_hour_inc` wrap.
- **Set inputs.** `i_min_inc` and `i_hour_inc` act regardless of `i_run`. Seconds are untouched by both.
- **Priority, high to low:** `rst`, then `i_clr`, then the set/carry advance.
  - `i_clr` forces `div_cnt`=0 and all digits to the reset time.
  - `i_clr` suppresses `o_tick` and `o_day` that cycle.
- **Digit rules.** All digits stay valid BCD at all times; no digit ever holds a value above 9, or above 5 for sec_h/min_h.

## Timing
- **Reset values:** `div_cnt`=0, `o_tick`=0, `o_day`=0, `o_bcd`=24'h000000 (24 h mode).
- **Registered outputs.** `o_tick`, `o_bcd` and `o_day` are all registered. On the edge where the divider wraps:
  - `o_tick` goes high for exactly one cycle;
  - `o_bcd` shows the advanced time in that same cycle;
  - `o_day` is high in that same cycle if the hour wrapped.
- **First tick.** After `rst` deasserts with `i_run`=1, the first `o_tick` is high in cycle `i_nco_num`, counting the first cycle after reset as cycle 1.
- **Tick period.** Successive ticks are `i_nco_num` running cycles apart. Cycles with `i_run`=0 stretch the period without losing count.
- **Set latency.** An `i_min_inc`/`i_hour_inc` pulse is visible on `o_bcd` one cycle later. A pulse held high for N cycles advances N times.
- **Reset mid-count.** `rst` or `i_clr` in any cycle restarts the divider from 0. The next tick follows a full `i_nco_num` cycles after deassertion.

## Configuration
- **Macro:** `NCO_HMS_12H_EN`.
- **Defined:** 12-hour mode.
  - Hours run 12,01,02…11,12; the reset/clear value is 12:00:00, so `o_bcd`=24'h120000.
  - `o_day` pulses on the 11:59:59→12:00:00 carry.
- **Undefined:** 24-hour mode, 00–23, reset value 00:00:00.

## Test plan
- `i_nco_num`=4, `i_run`=1, release `rst` → `o_tick` high in cycles 4, 8, 12; `o_bcd` = 24'h000001, 000002, 000003 in those cycles.
- `i_nco_num`=1, run 60 cycles from reset → `o_bcd`=24'h000100 after the 60th tick; sec_l never exceeds 9.
- Preload 23:59:59 via set pulses plus ticks, then one tick → `o_bcd`=24'h000000 and `o_day`=1 for one cycle. With `NCO_HMS_12H_EN`, 11:59:59 → 24'h120000 and `o_day`=1.
- Set-input independence:
  - at min=59, pulse `i_min_inc` → min=00 and hour unchanged;
  - pulse `i_hour_inc` at hour 23 → 00 with `o_day`=0;
  - a tick carry and `i_min_inc` in the same cycle advance the minute by one only.
- Run control: `i_run`=0 for 10 cycles mid-count with `i_nco_num`=4 → tick delayed by exactly 10 cycles. Assert `i_clr` mid-count → `o_bcd`=0 next cycle, then the next tick comes 4 cycles after `i_clr` drops.
- Lower `i_nco_num` from 100 to 3 while `div_cnt`=50 → wrap and `o_tick` on the next running cycle, then a period of 3.
